// File: rtl/core_pkg.sv
// Shared types and widths for the 9-bit-ISA core front end.
package core_pkg;

    localparam int unsigned ADDR_W  = 10;
    localparam int unsigned INSTR_W = 9;

    typedef logic [INSTR_W-1:0] instr_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_skid.sv
// One-entry instruction+pc holding slot for data returning while the fetch output is stalled.
module fetch_skid #(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned INSTR_W = 9
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push_i,
    input  logic               pop_i,
    input  logic               clear_i,
    input  logic [INSTR_W-1:0] data_i,
    input  logic [ADDR_W-1:0]  pc_i,
    output logic [INSTR_W-1:0] data_o,
    output logic [ADDR_W-1:0]  pc_o,
    output logic               full_o
);

    logic               full_q;
    logic [INSTR_W-1:0] data_q;
    logic [ADDR_W-1:0]  pc_q;

    // Push wins over pop so a simultaneous pop+push refills the slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            data_q <= '0;
            pc_q   <= '0;
        end else if (clear_i) begin
            full_q <= 1'b0;
        end else if (push_i) begin
            full_q <= 1'b1;
            data_q <= data_i;
            pc_q   <= pc_i;
        end else if (pop_i) begin
            full_q <= 1'b0;
        end
    end

    assign data_o = data_q;
    assign pc_o   = pc_q;
    assign full_o = full_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues imem reads for pc, registers instr+pc, absorbs stalls, flushes, drains on halt.
module fetch_stage #(
    parameter int unsigned ADDR_W  = core_pkg::ADDR_W,
    parameter int unsigned INSTR_W = core_pkg::INSTR_W,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               CLK,
    input  logic               init_n,
    input  logic               start,
    input  logic [ADDR_W-1:0]  pc,
    input  logic               halt,
    input  logic               stall,
    input  logic               flush,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic               imem_re,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    output logic [CNT_W-1:0]   fetch_count,
    output logic               done
);

    import core_pkg::*;

    fetch_state_t       state_q, state_d;
    logic               inflight_q, inflight_d;
    logic [ADDR_W-1:0]  inflight_pc_q, inflight_pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;
    logic               instr_valid_q, instr_valid_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;

    logic               issue_c;
    logic               accept_c;
    logic               skid_push, skid_pop, skid_clear, skid_full;
    logic [INSTR_W-1:0] skid_data;
    logic [ADDR_W-1:0]  skid_pc;

    fetch_skid #(
        .ADDR_W (ADDR_W),
        .INSTR_W(INSTR_W)
    ) u_skid (
        .clk    (CLK),
        .rst_n  (init_n),
        .push_i (skid_push),
        .pop_i  (skid_pop),
        .clear_i(skid_clear),
        .data_i (imem_rdata),
        .pc_i   (inflight_pc_q),
        .data_o (skid_data),
        .pc_o   (skid_pc),
        .full_o (skid_full)
    );

    assign accept_c = instr_valid_q && !stall;

    // Next-state, issue and output-register update.
    always_comb begin
        state_d       = state_q;
        issue_c       = 1'b0;
        cnt_d         = cnt_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        skid_push     = 1'b0;
        skid_pop      = 1'b0;
        skid_clear    = 1'b0;

        case (state_q)
            IDLE:  if (start) state_d = RUN;
            RUN: begin
                if (halt) state_d = DRAIN;
                else      issue_c = !stall && !skid_full;
            end
            DRAIN: begin
                if (!inflight_q && !skid_full && (!instr_valid_q || accept_c))
                    state_d = DONE;
            end
            DONE:  if (start) state_d = RUN;
            default: state_d = IDLE;
        endcase

        if ((state_q == IDLE || state_q == DONE) && start)
            cnt_d = '0;
        else if (accept_c && (cnt_q != '1))
            cnt_d = cnt_q + CNT_W'(1);

        if (flush) begin
            instr_valid_d = 1'b0;
            skid_clear    = 1'b1;
        end else if (!instr_valid_q || accept_c) begin
            if (skid_full) begin
                instr_d       = skid_data;
                instr_pc_d    = skid_pc;
                instr_valid_d = 1'b1;
                skid_pop      = 1'b1;
                skid_push     = inflight_q;
            end else if (inflight_q) begin
                instr_d       = imem_rdata;
                instr_pc_d    = inflight_pc_q;
                instr_valid_d = 1'b1;
            end else begin
                instr_valid_d = 1'b0;
            end
        end else begin
            skid_push = inflight_q;
        end

        inflight_d    = issue_c;
        inflight_pc_d = issue_c ? pc : inflight_pc_q;
        done_d        = (state_d == DONE);
    end

    always_ff @(posedge CLK or negedge init_n) begin
        if (!init_n) begin
            state_q       <= IDLE;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            cnt_q         <= '0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            cnt_q         <= cnt_d;
            done_q        <= done_d;
        end
    end

    assign imem_addr   = pc;
    assign imem_re     = issue_c;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;
    assign fetch_count = cnt_q;
    assign done        = done_q;

endmodule
